aes_round_ctrl: RTL and testbench

Control-only sequencer for the iterative AES-128 datapath. Accepts one block per valid/ready handshake, drives the datapath state-register load and mux selects through the initial AddRoundKey, nine full rounds and the final round, and requests the matching round key index from the key schedule. The `aes_addroundkey` XOR, SubBytes, ShiftRows and MixColumns stages stay combinational; this block owns only sequencing.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes_round_ctrl_if.sv | 41 ++++
 rtl/aes_round_counter.sv | 35 +++
 rtl/aes_round_ctrl.sv | 139 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int RIDX_W    = 4;
    localparam int AES_BLK_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round sequencer (slave)
// and the block that feeds it and consumes its selects (master).
// Optional decrypt signals exist only when AES_ROUND_CTRL_DECRYPT_EN is defined.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic              key_vld;
    logic [RIDX_W-1:0] round_idx;
    logic              state_ld;
    logic              sel_init;
    logic              skip_mix;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
    logic              dec;
    logic              inv_sel;
`endif

    modport slave (
        input  clear, in_valid, key_vld, out_ready,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        input  dec,
        output inv_sel,
`endif
        output in_ready, round_idx, state_ld, sel_init, skip_mix, out_valid, busy
    );

    modport master (
        output clear, in_valid, key_vld, out_ready,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        output dec,
        input  inv_sel,
`endif
        input  in_ready, round_idx, state_ld, sel_init, skip_mix, out_valid, busy
    );

endinterface

// File: rtl/aes_round_counter.sv
// Round key index counter: load / step up or down / hold, saturating at 0 and NR.
// tc flags the last full round: NR-1 counting up, 1 counting down.
module aes_round_counter
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [RIDX_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    output logic [RIDX_W-1:0] cnt,
    output logic              tc
);

    // Counter register; load wins over step, step never wraps past 0 or NR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (step) begin
            if (down) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else begin
                if (cnt < RIDX_W'(NR)) cnt <= cnt + 1'b1;
            end
        end
    end

    assign tc = down ? (cnt == RIDX_W'(1)) : (cnt == RIDX_W'(NR - 1));

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: initial AddRoundKey, NR-1 full
// rounds, final round, then hold the result until the consumer takes it.
// Define AES_ROUND_CTRL_DECRYPT_EN to add the dec input / inv_sel output and
// reverse the round key order for decryption.
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// INIT  | initial AddRoundKey, state mux takes the input block
// ROUND | full rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey)
// FINAL | last round, MixColumns bypassed
// DONE  | result held in state register, out_valid high
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic           clk,
    input  logic           rst_n,
    aes_round_ctrl_if.slave bus
);

    ctrl_state_t       state;
    ctrl_state_t       nstate;
    logic              cnt_load;
    logic [RIDX_W-1:0] cnt_val;
    logic              cnt_step;
    logic              cnt_down;
    logic              cnt_tc;
    logic [RIDX_W-1:0] ridx;
    logic [RIDX_W-1:0] start_val;

    logic in_ready_q;
    logic sel_init_q;
    logic skip_mix_q;
    logic out_valid_q;
    logic busy_q;
    logic ld_en_q;

`ifdef AES_ROUND_CTRL_DECRYPT_EN
    logic dec_q;

    // Direction is captured at acceptance and held for the whole block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b0;
        end else if (state == ST_IDLE && bus.in_valid && !bus.clear) begin
            dec_q <= bus.dec;
        end
    end

    assign cnt_down    = dec_q;
    assign start_val   = bus.dec ? RIDX_W'(NR) : '0;
    assign bus.inv_sel = dec_q;
`else
    assign cnt_down  = 1'b0;
    assign start_val = '0;
`endif

    // Next-state and counter command decode; clear beats every other input.
    always_comb begin
        nstate   = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_step = 1'b0;
        if (bus.clear) begin
            nstate   = ST_IDLE;
            cnt_load = 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    nstate   = ST_INIT;
                    cnt_load = 1'b1;
                    cnt_val  = start_val;
                end
                ST_INIT: if (bus.key_vld) begin
                    nstate   = ST_ROUND;
                    cnt_step = 1'b1;
                end
                ST_ROUND: if (bus.key_vld) begin
                    cnt_step = 1'b1;
                    if (cnt_tc) nstate = ST_FINAL;
                end
                ST_FINAL: if (bus.key_vld) begin
                    nstate = ST_DONE;
                end
                ST_DONE: if (bus.out_ready) begin
                    nstate   = ST_IDLE;
                    cnt_load = 1'b1;
                end
                default: begin
                    nstate   = ST_IDLE;
                    cnt_load = 1'b1;
                end
            endcase
        end
    end

    // State register with outputs decoded from the next state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            sel_init_q  <= 1'b0;
            skip_mix_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ld_en_q     <= 1'b0;
        end else begin
            state       <= nstate;
            in_ready_q  <= (nstate == ST_IDLE);
            sel_init_q  <= (nstate == ST_INIT);
            skip_mix_q  <= (nstate == ST_FINAL);
            out_valid_q <= (nstate == ST_DONE);
            busy_q      <= (nstate != ST_IDLE);
            ld_en_q     <= (nstate == ST_INIT) || (nstate == ST_ROUND) || (nstate == ST_FINAL);
        end
    end

    aes_round_counter #(.NR(NR)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .step     (cnt_step),
        .down     (cnt_down),
        .cnt      (ridx),
        .tc       (cnt_tc)
    );

    assign bus.round_idx = ridx;
    assign bus.in_ready  = in_ready_q;
    assign bus.sel_init  = sel_init_q;
    assign bus.skip_mix  = skip_mix_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    // Only input-dependent output: a load happens only when the round key is there.
    assign bus.state_ld  = ld_en_q & bus.key_vld;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl. Each accepted block pushes its
// expected sequence of state loads; a negedge monitor pops one per state_ld.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus();

    aes_round_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int idx;
        int sel;
        int skip;
    } ld_t;

    ld_t ld_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  cur_dec = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every datapath load must match the next expected round key index and selects.
    always @(negedge clk) begin
        ld_t e;
        if (rst_n && bus.state_ld === 1'b1) begin
            if (ld_q.size() == 0) begin
                check("extra_load", 1, 0);
            end else begin
                e = ld_q.pop_front();
                check("ld_round_idx", int'(bus.round_idx), e.idx);
                check("ld_sel_init", int'(bus.sel_init), e.sel);
                check("ld_skip_mix", int'(bus.skip_mix), e.skip);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input bit d);
        ld_t e;
        for (int k = 0; k <= 10; k++) begin
            e.idx  = d ? (10 - k) : k;
            e.sel  = (k == 0) ? 1 : 0;
            e.skip = (k == 10) ? 1 : 0;
            ld_q.push_back(e);
        end
    endtask

    // Drive one block through the acceptance edge; afterwards we are in cycle 1.
    task automatic accept(input bit d);
        cur_dec = d;
        push_block(d);
        bus.in_valid = 1'b1;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        bus.dec = d;
`endif
        tick();
        bus.in_valid = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        bus.dec = ~d;
`endif
        check("acc_busy", int'(bus.busy), 1);
        check("acc_in_ready", int'(bus.in_ready), 0);
        check("acc_sel_init", int'(bus.sel_init), 1);
        check("acc_round_idx", int'(bus.round_idx), d ? 10 : 0);
    endtask

    // Run from cycle cyc0 to out_valid, optionally stalling key_vld 3 cycles at
    // stall_idx, then hold out_ready low hold_n cycles and complete the handshake.
    task automatic finish_block(input int cyc0, input int exp_lat, input int stall_idx, input int hold_n);
        int cyc;
        bit stalled;
        cyc     = cyc0;
        stalled = 1'b0;
        while (bus.out_valid !== 1'b1 && cyc < 60) begin
            if (stall_idx >= 0 && !stalled && int'(bus.round_idx) == stall_idx) begin
                stalled     = 1'b1;
                bus.key_vld = 1'b0;
                repeat (3) begin
                    tick();
                    cyc++;
                    check("stall_hold_idx", int'(bus.round_idx), stall_idx);
                    check("stall_no_load", int'(bus.state_ld), 0);
                end
                bus.key_vld = 1'b1;
            end else begin
                tick();
                cyc++;
            end
`ifdef AES_ROUND_CTRL_DECRYPT_EN
            check("inv_sel", int'(bus.inv_sel), int'(cur_dec));
`endif
        end
        check("latency", cyc, exp_lat);
        check("loads_drained", ld_q.size(), 0);
        check("done_state_ld", int'(bus.state_ld), 0);
        repeat (hold_n) begin
            tick();
            check("hold_out_valid", int'(bus.out_valid), 1);
            check("hold_in_ready", int'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_in_ready", int'(bus.in_ready), 1);
        check("idle_out_valid", int'(bus.out_valid), 0);
        check("idle_busy", int'(bus.busy), 0);
        check("idle_round_idx", int'(bus.round_idx), 0);
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (int'(bus.round_idx) != target && n < 40) begin
            tick();
            n++;
            check("no_early_out_valid", int'(bus.out_valid), 0);
        end
        if (n >= 40) check("wait_idx_timeout", int'(bus.round_idx), target);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        check({tag, "_round_idx"}, int'(bus.round_idx), 0);
        check({tag, "_state_ld"}, int'(bus.state_ld), 0);
        check({tag, "_sel_init"}, int'(bus.sel_init), 0);
        check({tag, "_skip_mix"}, int'(bus.skip_mix), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        check({tag, "_inv_sel"}, int'(bus.inv_sel), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.key_vld   = 1'b0;
        bus.out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
        bus.dec       = 1'b0;
`endif
        #23;
        check_reset_vals("rst");
        rst_n = 1'b1;
        bus.key_vld = 1'b1;

        // Plain block, key always valid, result taken after 4 wait cycles.
        accept(1'b0);
        finish_block(1, 12, -1, 4);

        // Key stalled 3 cycles in round 5.
        accept(1'b0);
        finish_block(1, 15, 5, 0);

        // Clear in round 7 with in_valid high, new block accepted right after.
        accept(1'b0);
        wait_idx(7);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_round_idx", int'(bus.round_idx), 0);
        check("clr_in_ready", int'(bus.in_ready), 1);
        check("clr_out_valid", int'(bus.out_valid), 0);
        check("clr_busy", int'(bus.busy), 0);
        ld_q.delete();
        accept(1'b0);
        finish_block(1, 12, -1, 0);

        // Asynchronous reset in round 3, acceptance in the first cycle after release.
        accept(1'b0);
        wait_idx(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        ld_q.delete();
        rst_n = 1'b1;
        accept(1'b0);
        finish_block(1, 12, -1, 0);

`ifdef AES_ROUND_CTRL_DECRYPT_EN
        // Decrypt: keys 10 down to 0, then an encrypt block to see inv_sel drop.
        accept(1'b1);
        finish_block(1, 12, -1, 1);
        accept(1'b0);
        finish_block(1, 12, -1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
